// File: rtl/traffic_pkg.sv
// Shared types and constants for the multi-approach traffic light controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        HWY_GRN     = 3'd0,
        HWY_YEL     = 3'd1,
        CLR_TO_SIDE = 3'd2,
        SIDE_GRN    = 3'd3,
        SIDE_YEL    = 3'd4,
        CLR_TO_HWY  = 3'd5
    } state_t;

    localparam logic [2:0] LIGHT_GRN = 3'b001;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_RED = 3'b100;

    // Width of a side index; a single side still needs one bit.
    function automatic int side_w(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/traffic_rr_arb.sv
// Combinational round-robin pick: first requesting side at or after the pointer, wrapping.
module traffic_rr_arb
    import traffic_pkg::*;
#(
    parameter int NUM_SIDE = 2,
    parameter int SW       = side_w(NUM_SIDE)
) (
    input  logic [NUM_SIDE-1:0] req,
    input  logic [SW-1:0]       ptr,
    output logic [SW-1:0]       winner,
    output logic                valid
);

    // Scan from the pointer and take the first pending index.
    always_comb begin
        int idx;
        idx    = 0;
        winner = {SW{1'b0}};
        valid  = 1'b0;
        for (int k = 0; k < NUM_SIDE; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_SIDE) begin
                idx = idx - NUM_SIDE;
            end else begin
                idx = idx;
            end
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx[SW-1:0];
            end else begin
                valid  = valid;
                winner = winner;
            end
        end
    end

endmodule

// File: rtl/traffic_light_multi.sv
// Highway plus NUM_SIDE side roads, round-robin side service with yellow/all-red between phases.
// Optional emergency preemption is enabled by defining TRAFFIC_PREEMPT_EN.
module traffic_light_multi
    import traffic_pkg::*;
#(
    parameter int NUM_SIDE     = 2,
    parameter int CNT_W        = 8,
    parameter int YEL_HOLD     = 3,
    parameter int RED_CLR      = 1,
    parameter int HWY_GRN_MIN  = 5,
    parameter int SIDE_GRN_MIN = 4,
    parameter int SIDE_GRN_MAX = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_SIDE-1:0]             sensor,
`ifdef TRAFFIC_PREEMPT_EN
    input  logic                            preempt,
`endif
    output logic [2:0]                      light_highway,
    output logic [3*NUM_SIDE-1:0]           light_side,
    output logic [side_w(NUM_SIDE)-1:0]     active_side,
    output logic [NUM_SIDE-1:0]             req_pending
);

    localparam int SW = side_w(NUM_SIDE);

    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] HWY_MIN_C  = CNT_W'(HWY_GRN_MIN);
    localparam logic [CNT_W-1:0] YEL_C      = CNT_W'(YEL_HOLD);
    localparam logic [CNT_W-1:0] RED_C      = CNT_W'(RED_CLR);
    localparam logic [CNT_W-1:0] SIDE_MIN_C = CNT_W'(SIDE_GRN_MIN);
    localparam logic [CNT_W-1:0] SIDE_MAX_C = CNT_W'(SIDE_GRN_MAX);
    localparam logic [SW-1:0]    LAST_SIDE  = SW'(NUM_SIDE - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_SIDE-1:0]   req_q, req_d;
    logic [SW-1:0]         active_q, active_d;
    logic [SW-1:0]         ptr_q, ptr_d;
    logic                  cnt_rst;
    logic                  pre_act;
    logic [SW-1:0]         rr_win;
    logic                  rr_valid;

`ifdef TRAFFIC_PREEMPT_EN
    assign pre_act = preempt;
`else
    assign pre_act = 1'b0;
`endif

    traffic_rr_arb #(
        .NUM_SIDE (NUM_SIDE),
        .SW       (SW)
    ) u_rr_arb (
        .req    (req_q),
        .ptr    (ptr_q),
        .winner (rr_win),
        .valid  (rr_valid)
    );

    // Phase sequencing; clearance phases hold with a restarted counter while preempted.
    always_comb begin
        state_d = state_q;
        cnt_rst = 1'b0;
        case (state_q)
            HWY_GRN: begin
                if (pre_act || ((|req_q) && (cnt_q >= HWY_MIN_C))) state_d = HWY_YEL;
                else state_d = HWY_GRN;
            end
            HWY_YEL: begin
                if (cnt_q >= YEL_C) state_d = CLR_TO_SIDE;
                else state_d = HWY_YEL;
            end
            CLR_TO_SIDE: begin
                if (pre_act) cnt_rst = 1'b1;
                else if (cnt_q >= RED_C) state_d = SIDE_GRN;
                else state_d = CLR_TO_SIDE;
            end
            SIDE_GRN: begin
                if (pre_act || (cnt_q >= SIDE_MAX_C) ||
                    (!sensor[active_q] && (cnt_q >= SIDE_MIN_C))) state_d = SIDE_YEL;
                else state_d = SIDE_GRN;
            end
            SIDE_YEL: begin
                if (cnt_q >= YEL_C) state_d = CLR_TO_HWY;
                else state_d = SIDE_YEL;
            end
            CLR_TO_HWY: begin
                if (pre_act) cnt_rst = 1'b1;
                else if (cnt_q >= RED_C) state_d = HWY_GRN;
                else state_d = CLR_TO_HWY;
            end
            default: begin
                state_d = HWY_GRN;
            end
        endcase

        if ((state_d != state_q) || cnt_rst) cnt_d = {CNT_W{1'b0}};
        else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
        else cnt_d = cnt_q + CNT_W'(1);
    end

    // Grant bookkeeping: winner is captured as the highway starts yielding.
    always_comb begin
        active_d = active_q;
        ptr_d    = ptr_q;
        if ((state_q == HWY_GRN) && (state_d == HWY_YEL) && rr_valid) begin
            active_d = rr_win;
            if (rr_win == LAST_SIDE) ptr_d = {SW{1'b0}};
            else ptr_d = rr_win + SW'(1);
        end else begin
            active_d = active_q;
            ptr_d    = ptr_q;
        end

        req_d = req_q;
        for (int i = 0; i < NUM_SIDE; i++) begin
            if ((state_q == SIDE_GRN) && (active_q == SW'(i))) req_d[i] = 1'b0;
            else req_d[i] = req_q[i] | sensor[i];
        end
    end

    // State, counter and request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= HWY_GRN;
            cnt_q    <= {CNT_W{1'b0}};
            req_q    <= {NUM_SIDE{1'b0}};
            active_q <= {SW{1'b0}};
            ptr_q    <= {SW{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            active_q <= active_d;
            ptr_q    <= ptr_d;
        end
    end

    // Light decode straight from state so reset shows safe lights in the same cycle.
    always_comb begin
        logic [2:0] side_lamp;
        light_highway = LIGHT_RED;
        side_lamp     = LIGHT_RED;
        case (state_q)
            HWY_GRN:     light_highway = LIGHT_GRN;
            HWY_YEL:     light_highway = LIGHT_YEL;
            CLR_TO_SIDE: light_highway = LIGHT_RED;
            SIDE_GRN:    side_lamp     = LIGHT_GRN;
            SIDE_YEL:    side_lamp     = LIGHT_YEL;
            CLR_TO_HWY:  light_highway = LIGHT_RED;
            default:     light_highway = LIGHT_GRN;
        endcase
        light_side = {NUM_SIDE{LIGHT_RED}};
        for (int i = 0; i < NUM_SIDE; i++) begin
            if (active_q == SW'(i)) light_side[3*i +: 3] = side_lamp;
            else light_side[3*i +: 3] = LIGHT_RED;
        end
    end

    assign active_side = active_q;
    assign req_pending = req_q;

endmodule
